// File: rtl/fxu_reservation_station_pkg.sv
// Shared types and constants for the fixed-point-unit reservation station.
// Contents:
//   RS_DEPTH / DATA_W / TAG_W / OP_W  default geometry
//   rs_entry_t                        one stored instruction with both operands
//   operand_hit()                     result-bus capture condition for one operand
package fxu_reservation_station_pkg;

  localparam int RS_DEPTH = 4;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 4;
  localparam int OP_W     = 4;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  rob_tag;
    logic              a_valid;
    logic [DATA_W-1:0] a_value;
    logic [TAG_W-1:0]  a_owner;
    logic              b_valid;
    logic [DATA_W-1:0] b_value;
    logic [TAG_W-1:0]  b_owner;
  } rs_entry_t;

  // A pending operand captures the broadcast when its producer tag is on the bus.
  function automatic logic operand_hit(
    input logic             op_valid,
    input logic [TAG_W-1:0] op_owner,
    input logic             cdb_valid,
    input logic [TAG_W-1:0] cdb_tag
  );
    return (~op_valid) & cdb_valid & (op_owner == cdb_tag);
  endfunction

endpackage

// File: rtl/fxu_reservation_station_if.sv
// Bundle of dispatch, result-bus and issue signals for the reservation station.
//   master : producer side (instruction buffer, result bus, FXU ready, flush)
//   slave  : the reservation station itself
interface fxu_reservation_station_if;
  import fxu_reservation_station_pkg::*;

  logic              flush;
  logic              disp_valid;
  logic [OP_W-1:0]   disp_opcode;
  logic [TAG_W-1:0]  disp_rob_tag;
  logic              disp_a_valid;
  logic [DATA_W-1:0] disp_a_value;
  logic [TAG_W-1:0]  disp_a_owner;
  logic              disp_b_valid;
  logic [DATA_W-1:0] disp_b_value;
  logic [TAG_W-1:0]  disp_b_owner;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_opcode;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [TAG_W-1:0]  iss_rob_tag;

  modport master (
    output flush, disp_valid, disp_opcode, disp_rob_tag,
           disp_a_valid, disp_a_value, disp_a_owner,
           disp_b_valid, disp_b_value, disp_b_owner,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  full, iss_valid, iss_opcode, iss_a, iss_b, iss_rob_tag
  );

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_rob_tag,
           disp_a_valid, disp_a_value, disp_a_owner,
           disp_b_valid, disp_b_value, disp_b_owner,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output full, iss_valid, iss_opcode, iss_a, iss_b, iss_rob_tag
  );

endinterface

// File: rtl/fxu_reservation_station_rs_operand_capture.sv
// Combinational wakeup for a single operand: if the operand is still waiting and
// its producer tag is on the result bus, the broadcast value replaces it.
// Ports:
//   op_valid/op_value/op_owner    operand as currently held
//   cdb_valid/cdb_tag/cdb_value   result bus
//   out_valid/out_value           operand after this cycle's capture
module rs_operand_capture
  import fxu_reservation_station_pkg::*;
(
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_value,
  input  logic [TAG_W-1:0]  op_owner,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_value
);

  logic hit_s;

  assign hit_s     = operand_hit(op_valid, op_owner, cdb_valid, cdb_tag);
  assign out_valid = op_valid | hit_s;
  assign out_value = hit_s ? cdb_value : op_value;

endmodule

// File: rtl/fxu_reservation_station.sv
// Age-ordered reservation station for one fixed-point unit.
// Entry 0 is the oldest; the queue compacts when an entry issues. Pending
// operands are captured from the result bus, and the oldest entry with both
// operands ready is offered to the FXU through a valid/ready handshake.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave modport: flush, dispatch, full, result bus, issue handshake
module fxu_reservation_station
  import fxu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic clk,
  input  logic rst,
  fxu_reservation_station_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t         entries_r      [DEPTH];
  rs_entry_t         entries_next_s [DEPTH];
  // One extra empty slot so the top entry can shift in "nothing".
  rs_entry_t         woken_s        [DEPTH+1];
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W-1:0]  count_after_s;
  logic [DEPTH-1:0]  ready_s;
  logic [DEPTH-1:0]  shift_s;
  logic [DEPTH-1:0]  wake_a_valid_s;
  logic [DEPTH-1:0]  wake_b_valid_s;
  logic [DATA_W-1:0] wake_a_value_s [DEPTH];
  logic [DATA_W-1:0] wake_b_value_s [DEPTH];
  rs_entry_t         iss_entry_s;
  rs_entry_t         disp_entry_s;
  logic              iss_valid_s;
  logic              fire_s;
  logic              accept_s;
  logic              full_s;
  logic              byp_a_valid_s;
  logic              byp_b_valid_s;
  logic [DATA_W-1:0] byp_a_value_s;
  logic [DATA_W-1:0] byp_b_value_s;

  // Per-entry operand wakeup against the result bus.
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_operand_capture u_cap_a (
      .op_valid  (entries_r[g].a_valid),
      .op_value  (entries_r[g].a_value),
      .op_owner  (entries_r[g].a_owner),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_value (bus.cdb_value),
      .out_valid (wake_a_valid_s[g]),
      .out_value (wake_a_value_s[g])
    );
    rs_operand_capture u_cap_b (
      .op_valid  (entries_r[g].b_valid),
      .op_value  (entries_r[g].b_value),
      .op_owner  (entries_r[g].b_owner),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_value (bus.cdb_value),
      .out_valid (wake_b_valid_s[g]),
      .out_value (wake_b_value_s[g])
    );
  end

  // Dispatch bypass: an operand produced in the dispatch cycle is stored ready.
  rs_operand_capture u_byp_a (
    .op_valid  (bus.disp_a_valid),
    .op_value  (bus.disp_a_value),
    .op_owner  (bus.disp_a_owner),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_value (bus.cdb_value),
    .out_valid (byp_a_valid_s),
    .out_value (byp_a_value_s)
  );
  rs_operand_capture u_byp_b (
    .op_valid  (bus.disp_b_valid),
    .op_value  (bus.disp_b_value),
    .op_owner  (bus.disp_b_owner),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_value (bus.cdb_value),
    .out_valid (byp_b_valid_s),
    .out_value (byp_b_value_s)
  );

  // Assemble the incoming entry with bypassed operands.
  always_comb begin
    disp_entry_s         = '0;
    disp_entry_s.valid   = 1'b1;
    disp_entry_s.opcode  = bus.disp_opcode;
    disp_entry_s.rob_tag = bus.disp_rob_tag;
    disp_entry_s.a_valid = byp_a_valid_s;
    disp_entry_s.a_value = byp_a_value_s;
    disp_entry_s.a_owner = bus.disp_a_owner;
    disp_entry_s.b_valid = byp_b_valid_s;
    disp_entry_s.b_value = byp_b_value_s;
    disp_entry_s.b_owner = bus.disp_b_owner;
  end

  // Stored entries with this cycle's wakeups applied (next-state view only).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i]         = entries_r[i];
      woken_s[i].a_valid = wake_a_valid_s[i];
      woken_s[i].a_value = wake_a_value_s[i];
      woken_s[i].b_valid = wake_b_valid_s[i];
      woken_s[i].b_value = wake_b_value_s[i];
    end
    woken_s[DEPTH] = '0;
  end

  // Readiness uses registered operands, so a wakeup cannot issue in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = entries_r[i].valid & entries_r[i].a_valid & entries_r[i].b_valid;
    end
  end

  // Priority select: scanning from the top lets the lowest ready index win.
  always_comb begin
    iss_entry_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      iss_entry_s = ready_s[i] ? entries_r[i] : iss_entry_s;
    end
    iss_valid_s = |ready_s;
  end

  assign fire_s        = iss_valid_s & bus.iss_ready;
  assign full_s        = (count_r == CNT_W'(DEPTH));
  assign accept_s      = bus.disp_valid & ~full_s;
  assign count_after_s = count_r - CNT_W'(fire_s);

  // Entries at or above the issued one shift down; running OR marks them.
  always_comb begin
    logic seen_s;
    seen_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      seen_s     = seen_s | ready_s[i];
      shift_s[i] = fire_s & seen_s;
    end
  end

  // Next-state: flush clears; otherwise compact, then append the dispatch at the tail.
  always_comb begin
    count_next_s = count_r;
    for (int i = 0; i < DEPTH; i++) begin
      entries_next_s[i] = '0;
    end
    if (bus.flush) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_after_s + CNT_W'(accept_s);
      for (int i = 0; i < DEPTH; i++) begin
        if (accept_s && (CNT_W'(i) == count_after_s)) begin
          entries_next_s[i] = disp_entry_s;
        end else if (shift_s[i]) begin
          entries_next_s[i] = woken_s[i+1];
        end else begin
          entries_next_s[i] = woken_s[i];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      count_r <= count_next_s;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entries_next_s[i];
      end
    end
  end

  assign bus.full        = full_s;
  assign bus.iss_valid   = iss_valid_s;
  assign bus.iss_opcode  = iss_entry_s.opcode;
  assign bus.iss_a       = iss_entry_s.a_value;
  assign bus.iss_b       = iss_entry_s.b_value;
  assign bus.iss_rob_tag = iss_entry_s.rob_tag;

endmodule
